// File: rtl/pixel_write_master.sv
// Pixel write master: buffers Draw/Write_Finish pixel handshakes in a FIFO and
// issues single-beat Avalon-MM writes to the SDRAM pixel buffer.
module pixel_write_master #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  Draw,
    input  logic [ADDR_W-1:0]     Pixel_Address,
    input  logic [DATA_W-1:0]     Color,
    output logic                  Write_Finish,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  Idle,
    output logic [15:0]           Pixel_Count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PCNT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    pixel_t              r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    state_t              r_state;
    logic                r_write_finish;
    logic                r_avm_write;
    logic [ADDR_W-1:0]   r_avm_address;
    logic [DATA_W-1:0]   r_avm_writedata;
    logic                r_idle;
    logic [PCNT_W-1:0]   r_pixel_count;

    logic                w_fifo_empty;
    logic                w_accept;
    logic                w_pop;
    pixel_t              w_head;

    // Full test uses the registered count, so a same-cycle pop never frees a slot early.
    assign w_fifo_empty = (r_count == '0);
    assign w_accept     = Draw & (r_count < CNT_W'(FIFO_DEPTH)) & ~r_write_finish;
    assign w_pop        = ~w_fifo_empty & ((r_state == S_IDLE) | ~avm_waitrequest);
    assign w_head       = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= pixel_t'{addr: Pixel_Address, color: Color};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_write_finish <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count        <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
            r_write_finish <= w_accept;
        end
    end

    // Write FSM: bus held stable under waitrequest, back-to-back pops when data waits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_pixel_count   <= '0;
            r_idle          <= 1'b1;
        end else begin
            r_idle <= w_fifo_empty & (r_state == S_IDLE) & ~Draw;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_avm_address   <= w_head.addr;
                        r_avm_writedata <= w_head.color;
                        r_avm_write     <= 1'b1;
                        r_state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        r_pixel_count <= r_pixel_count + PCNT_W'(1);
                        if (w_pop) begin
                            r_avm_address   <= w_head.addr;
                            r_avm_writedata <= w_head.color;
                        end else begin
                            r_avm_write <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_avm_write <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign Write_Finish   = r_write_finish;
    assign avm_address    = r_avm_address;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = '1;
    assign Idle           = r_idle;
    assign Pixel_Count    = r_pixel_count;

endmodule

// File: tb/tb_pixel_write_master.sv
// Randomized bench for pixel_write_master: a pixel-order scoreboard plus directed
// reset, stall/full, back-to-back and reset-during-write scenarios.
module tb_pixel_write_master;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] color;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Draw = 1'b0;
    logic [31:0] Pixel_Address = '0;
    logic [15:0] Color = '0;
    logic        Write_Finish;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic        Idle;
    logic [15:0] Pixel_Count;

    int          n_checks = 0;
    int          n_pass = 0;
    bit          wr_rand = 1'b0;
    bit          wr_fixed = 1'b0;

    pix_t        exp_q[$];
    pix_t        mon_e;
    logic [15:0] model_count = '0;
    bit          prev_stall = 1'b0;
    bit          prev_wf = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic [31:0] last_addr = '0;
    logic [15:0] last_color = '0;

    pixel_write_master #(
        .FIFO_DEPTH(8),
        .ADDR_W(32),
        .DATA_W(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .Draw(Draw),
        .Pixel_Address(Pixel_Address),
        .Color(Color),
        .Write_Finish(Write_Finish),
        .avm_address(avm_address),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .Idle(Idle),
        .Pixel_Count(Pixel_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Slave stall generator, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            avm_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : wr_fixed;
        end
    end

    // Reference model: every Write_Finish enqueues the pixel presented at the accepting
    // edge; every unstalled write must deliver the oldest one and bump the count.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            model_count = '0;
            prev_stall  = 1'b0;
            prev_wf     = 1'b0;
        end else begin
            if (Write_Finish) begin
                chk("wf_one_cycle", 32'(prev_wf), 32'd0);
                mon_e.addr  = last_addr;
                mon_e.color = last_color;
                exp_q.push_back(mon_e);
            end
            chk("pixel_count", 32'(Pixel_Count), 32'(model_count));
            if (prev_stall) begin
                chk("hold_write", 32'(avm_write), 32'd1);
                chk("hold_addr", avm_address, prev_addr);
                chk("hold_data", 32'(avm_writedata), 32'(prev_data));
            end
            if (avm_write && !avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk("write_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", avm_address, mon_e.addr);
                    chk("write_data", 32'(avm_writedata), 32'(mon_e.color));
                end
                model_count = model_count + 16'd1;
            end
            prev_stall = avm_write & avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
            prev_wf    = Write_Finish;
        end
        last_addr  = Pixel_Address;
        last_color = Color;
    end

    // Present one pixel and hold Draw until its Write_Finish; reports cycles waited.
    task automatic draw_pixel(input logic [31:0] a, input logic [15:0] c,
                              input int budget, output int waited);
        Draw = 1'b1;
        Pixel_Address = a;
        Color = c;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            waited++;
            if (Write_Finish) return;
        end
        chk("draw_accept", 32'(Write_Finish), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        @(negedge clk);
        for (i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int pulses;
        int idx;
        logic [31:0] base;

        // Reset held with Draw asserted
        Draw = 1'b1;
        Pixel_Address = 32'h0000_1234;
        Color = 16'hABCD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wf", 32'(Write_Finish), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_idle", 32'(Idle), 32'd1);
        chk("rst_count", 32'(Pixel_Count), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_data", 32'(avm_writedata), 32'd0);
        chk("byteenable", 32'(avm_byteenable), 32'd3);
        @(posedge clk);
        #1;
        Draw = 1'b0;
        resetn = 1'b1;

        // Single pixel
        draw_pixel(32'h0900_0000, 16'hFFFF, 20, w);
        chk("single_latency", 32'(w), 32'd1);
        Draw = 1'b0;
        wait_drain(50);
        chk("single_count", 32'(Pixel_Count), 32'd1);
        chk("single_idle", 32'(Idle), 32'd1);

        // Stall with 12 pixels offered: 8 buffered plus 1 in flight
        wr_fixed = 1'b1;
        @(posedge clk);
        #1;
        base = 32'h0900_1000;
        pulses = 0;
        idx = 0;
        Draw = 1'b1;
        Pixel_Address = base;
        Color = 16'($urandom);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Write_Finish) begin
                pulses++;
                idx++;
                if (idx < 12) begin
                    Pixel_Address = base + 32'(2 * idx);
                    Color = 16'($urandom);
                end else begin
                    Draw = 1'b0;
                end
            end
        end
        chk("stall_pulses", 32'(pulses), 32'd9);
        chk("stall_not_idle", 32'(Idle), 32'd0);
        Draw = 1'b0;
        wr_fixed = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b2b_write", 32'(avm_write), 32'd1);
        end
        @(negedge clk);
        chk("b2b_end", 32'(avm_write), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 9; i < 12; i++) draw_pixel(base + 32'(2 * i), 16'($urandom), 20, w);
        Draw = 1'b0;
        wait_drain(100);
        chk("stall_count", 32'(Pixel_Count), 32'd13);

        // Back-to-back drawing: accept every second cycle; one odd address passes through
        base = 32'h0900_2000;
        for (int i = 0; i < 20; i++) begin
            draw_pixel((i == 5) ? (base + 32'(2 * i) + 32'd1) : (base + 32'(2 * i)),
                       16'($urandom), 20, w);
            chk("wf_spacing", 32'(w), (i == 0) ? 32'd1 : 32'd2);
        end
        Draw = 1'b0;
        wait_drain(100);
        chk("b2b_count", 32'(Pixel_Count), 32'd33);

        // Reset during a stalled write with pixels queued
        wr_fixed = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) draw_pixel(32'h0900_3000 + 32'(2 * i), 16'($urandom), 20, w);
        Draw = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_write", 32'(avm_write), 32'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_write", 32'(avm_write), 32'd0);
        chk("midrst_count", 32'(Pixel_Count), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wr_fixed = 1'b0;
        chk("midrst_idle", 32'(Idle), 32'd1);
        draw_pixel(32'h0900_4000, 16'h1234, 20, w);
        chk("post_rst_latency", 32'(w), 32'd1);
        Draw = 1'b0;
        wait_drain(50);
        chk("post_rst_count", 32'(Pixel_Count), 32'd1);

        // Random traffic under random waitrequest
        wr_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap != 0) begin
                Draw = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            draw_pixel($urandom, 16'($urandom), 100, w);
        end
        Draw = 1'b0;
        wr_rand = 1'b0;
        wait_drain(2000);
        chk("rand_count", 32'(Pixel_Count), 32'd151);
        chk("rand_idle", 32'(Idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
